sfx_event_scheduler: RTL and testbench

//  Upstream feeder for the audio tone generator. Edge-detects raw game-event levels, queues them, and replays them as

---
 rtl/sfx_event_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sfx_event_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_event_scheduler.sv
// sfx_event_scheduler
//   Feeds the audio tone generator. Raw game-event levels are edge-detected,
//   queued, and replayed as single-cycle shot/collision strobes. The strobes
//   are spaced so each sound plays in full before the next one starts. A
//   queued hit may cut short a shot sound that is playing. A game_over edge
//   sets a sticky Reached_Bottom mute, which silences the scheduler until reset.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active low
//   shot_req        level: fire button / missile launched
//   hit_req         level: collision detected
//   game_over       level: invaders reached bottom
//   shot            1-cycle strobe, start shot sound
//   collision       1-cycle strobe, start collision sound
//   Reached_Bottom  sticky mute to the audio block
//   busy            high while a strobe is issuing or a sound is playing
//   fifo_count      queued events
//   dropped_cnt     events lost to a full queue, saturating at 255
//
// Timing
//   One sound occupies ISSUE (1 cycle) plus PLAY (SOUND_CYCLES+GUARD_CYCLES-1
//   cycles). The IDLE pop cycle follows, so back-to-back strobes are
//   SOUND_CYCLES+GUARD_CYCLES+1 cycles apart.
module sfx_event_scheduler #(
  parameter int SOUND_CYCLES = 12000000,
  parameter int GUARD_CYCLES = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shot_req,
  input  logic                          hit_req,
  input  logic                          game_over,
  output logic                          shot,
  output logic                          collision,
  output logic                          Reached_Bottom,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    dropped_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SOUND_CYCLES + GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  timer, timer_nx;
  logic              cur_is_hit, cur_is_hit_nx;

  // edge-detect history and registered edges
  logic              shot_q, hit_q, go_q;
  logic              shot_ev, hit_ev;

  // event queue: 1 bit per entry, 1 = hit
  logic [FIFO_DEPTH-1:0] mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              head, full, pop, push_req, push_ok, drop;
  logic              rb_set, flush;

  assign head     = mem[rd_ptr];
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  // A hit wins a same-cycle tie; the shot is discarded silently.
  assign push_req = shot_ev | hit_ev;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // The flush starts on the same edge that sets the mute, so a strobe that
  // is already issuing completes but no new one is started.
  assign rb_set   = game_over & ~go_q;
  assign flush    = Reached_Bottom | rb_set;

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    cur_is_hit_nx = cur_is_hit;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop           = 1'b1;
          cur_is_hit_nx = head;
          state_nx      = ISSUE;
        end
      end
      ISSUE: begin
        timer_nx = LOAD;
        state_nx = PLAY;
      end
      PLAY: begin
        // Only a hit at the head can cut a shot short; hits are never cut.
        if (!cur_is_hit && fifo_count != '0 && head) begin
          pop           = 1'b1;
          cur_is_hit_nx = 1'b1;
          state_nx      = ISSUE;
        end else if (timer <= CNT_W'(1)) begin
          timer_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      timer          <= '0;
      cur_is_hit     <= 1'b0;
      shot_q         <= 1'b0;
      hit_q          <= 1'b0;
      go_q           <= 1'b0;
      shot_ev        <= 1'b0;
      hit_ev         <= 1'b0;
      mem            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      dropped_cnt    <= '0;
      shot           <= 1'b0;
      collision      <= 1'b0;
      busy           <= 1'b0;
      Reached_Bottom <= 1'b0;
    end else begin
      shot_q  <= shot_req;
      hit_q   <= hit_req;
      go_q    <= game_over;
      shot_ev <= shot_req & ~shot_q;
      hit_ev  <= hit_req & ~hit_q;
      if (rb_set) Reached_Bottom <= 1'b1;

      if (flush) begin
        state      <= IDLE;
        timer      <= '0;
        cur_is_hit <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        shot       <= 1'b0;
        collision  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        state      <= state_nx;
        timer      <= timer_nx;
        cur_is_hit <= cur_is_hit_nx;
        if (push_ok) begin
          mem[wr_ptr] <= hit_ev;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
        if (drop && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
        // Strobes and busy are registered from the next state so they line
        // up exactly with the ISSUE/PLAY cycles.
        shot      <= (state_nx == ISSUE) & ~cur_is_hit_nx;
        collision <= (state_nx == ISSUE) &  cur_is_hit_nx;
        busy      <= (state_nx != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_sfx_event_scheduler.sv
module tb_sfx_event_scheduler;
  localparam int S  = 16;
  localparam int G  = 2;
  localparam int D  = 4;
  localparam int SG = S + G;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shot_req = 1'b0, hit_req = 1'b0, game_over = 1'b0;
  logic       shot, collision, Reached_Bottom, busy;
  logic [2:0] fifo_count;
  logic [7:0] dropped_cnt;

  sfx_event_scheduler #(.SOUND_CYCLES(S), .GUARD_CYCLES(G), .FIFO_DEPTH(D), .CNT_W(25)) dut (
    .clk(clk), .rst(rst), .shot_req(shot_req), .hit_req(hit_req), .game_over(game_over),
    .shot(shot), .collision(collision), .Reached_Bottom(Reached_Bottom), .busy(busy),
    .fifo_count(fifo_count), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model. It tracks the queue contents, the time of the last
  // strobe, and that strobe's type. A sound occupies the SG cycles starting
  // at its strobe. After that the scheduler is free, and a pop in a free
  // cycle gives a strobe on the following cycle.
  int cyc = 0;
  int q[$];
  bit p_shot, p_hit, p_go, pend_s, pend_h, m_rb, has_last, last_hit;
  bit e_shot, e_col, e_busy, m_flush, m_pop, m_nh;
  int last_t, m_drop, c;

  always @(posedge clk) begin
    c = cyc;
    if (!rst) begin
      q.delete();
      {p_shot, p_hit, p_go, pend_s, pend_h, m_rb, has_last, last_hit} = '0;
      {e_shot, e_col, e_busy} = '0;
      m_drop = 0;
      last_t = 0;
    end else begin
      m_flush = m_rb || (game_over && !p_go);
      m_pop = 0;
      m_nh = 0;
      if (q.size() > 0) begin
        if (!has_last || c >= last_t + SG) begin
          m_pop = 1;
          m_nh = (q[0] == 1);
        end else if (c > last_t && !last_hit && q[0] == 1) begin
          m_pop = 1;
          m_nh = 1;
        end
      end
      if (m_flush) begin
        q.delete();
        has_last = 0;
        m_pop = 0;
      end else begin
        if (m_pop) begin
          void'(q.pop_front());
          has_last = 1;
          last_t = c + 1;
          last_hit = m_nh;
        end
        if (pend_s || pend_h) begin
          if (q.size() < D) q.push_back(pend_h ? 1 : 0);
          else if (m_drop < 255) m_drop++;
        end
      end
      if (game_over && !p_go) m_rb = 1;
      pend_s = shot_req && !p_shot;
      pend_h = hit_req && !p_hit;
      p_shot = shot_req;
      p_hit  = hit_req;
      p_go   = game_over;
      e_shot = m_pop && !m_nh;
      e_col  = m_pop && m_nh;
      e_busy = has_last && (c + 1) < last_t + SG;
    end
    cyc = c + 1;
  end

  // per-cycle comparison plus strobe logs for the directed checks
  int shot_log[$], hit_log[$];
  int busy_cnt = 0, fifo_max = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("shot", int'(shot), int'(e_shot));
      chk("collision", int'(collision), int'(e_col));
      chk("busy", int'(busy), int'(e_busy));
      chk("fifo_count", int'(fifo_count), q.size());
      chk("dropped_cnt", int'(dropped_cnt), m_drop);
      chk("Reached_Bottom", int'(Reached_Bottom), int'(m_rb));
      if (shot === 1'b1) shot_log.push_back(cyc);
      if (collision === 1'b1) hit_log.push_back(cyc);
      if (busy === 1'b1) busy_cnt++;
      if (int'(fifo_count) > fifo_max) fifo_max = int'(fifo_count);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    shot_log.delete();
    hit_log.delete();
    busy_cnt = 0;
    fifo_max = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    shot_req = 1'b0;
    hit_req = 1'b0;
    game_over = 1'b0;
    tick(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fifo", int'(fifo_count), 0);
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_shot();
    shot_req = 1'b1; tick(1); shot_req = 1'b0; tick(1);
  endtask

  int r, t0, hr;

  initial begin
    #500000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(1);

    // single shot: latency, strobe width, busy length
    do_reset();
    r = cyc;
    pulse_shot();
    tick(30);
    chk("t1_nshot", shot_log.size(), 1);
    if (shot_log.size() > 0) chk("t1_latency", shot_log[0] - r, 3);
    chk("t1_ncol", hit_log.size(), 0);
    chk("t1_busy_len", busy_cnt, SG);

    // held level gives a single event
    do_reset();
    shot_req = 1'b1; tick(100); shot_req = 1'b0; tick(30);
    chk("t2_nshot", shot_log.size(), 1);
    chk("t2_drop", int'(dropped_cnt), 0);

    // three edges, strobes spaced SG+1
    do_reset();
    repeat (3) pulse_shot();
    tick(70);
    chk("t3_nshot", shot_log.size(), 3);
    if (shot_log.size() == 3) begin
      chk("t3_gap1", shot_log[1] - shot_log[0], SG + 1);
      chk("t3_gap2", shot_log[2] - shot_log[1], SG + 1);
    end
    chk("t3_fifo_peak", fifo_max, 2);
    chk("t3_fifo_end", int'(fifo_count), 0);

    // hit preempts a playing shot
    do_reset();
    pulse_shot();
    for (int k = 0; k < 50 && shot_log.size() == 0; k++) tick(1);
    chk("t4_wait_shot", shot_log.size(), 1);
    if (shot_log.size() > 0) begin
      t0 = shot_log[0];
      if (t0 + 5 > cyc) tick(t0 + 5 - cyc);
      hr = cyc;
      hit_req = 1'b1; tick(1); hit_req = 1'b0;
      shot_req = 1'b1; tick(1); shot_req = 1'b0;
      tick(60);
      chk("t4_ncol", hit_log.size(), 1);
      if (hit_log.size() > 0) begin
        chk("t4_col_lat", hit_log[0] - hr, 3);
        chk("t4_before_end", int'(hit_log[0] < t0 + SG), 1);
        chk("t4_nshot", shot_log.size(), 2);
        if (shot_log.size() == 2) chk("t4_next_gap", shot_log[1] - hit_log[0], SG + 1);
      end
    end

    // overflow during one sound, then saturation
    do_reset();
    pulse_shot();
    tick(2);
    repeat (6) pulse_shot();
    tick(1);
    chk("t5_fifo_full", int'(fifo_count), 4);
    chk("t5_drop2", int'(dropped_cnt), 2);
    repeat (300) pulse_shot();
    chk("t5_drop_sat", int'(dropped_cnt), 255);
    repeat (4) pulse_shot();
    chk("t5_drop_hold", int'(dropped_cnt), 255);

    // game over with events queued
    do_reset();
    repeat (4) pulse_shot();
    tick(1);
    chk("t6_queued", int'(fifo_count), 3);
    game_over = 1'b1;
    tick(1);
    chk("t6_rb", int'(Reached_Bottom), 1);
    chk("t6_flush", int'(fifo_count), 0);
    clear_logs();
    for (int k = 0; k < 100; k++) begin
      shot_req = 1'($urandom_range(0, 1));
      hit_req  = 1'($urandom_range(0, 1));
      tick(1);
    end
    chk("t6_no_shot", shot_log.size(), 0);
    chk("t6_no_col", hit_log.size(), 0);
    chk("t6_rb_hold", int'(Reached_Bottom), 1);
    rst = 1'b0; game_over = 1'b0; shot_req = 1'b0; hit_req = 1'b0;
    tick(1);
    chk("t6_rb_clr", int'(Reached_Bottom), 0);
    rst = 1'b1;

    // random traffic, including mid-sound resets and game over
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0)  shot_req = ~shot_req;
      if ($urandom_range(0, 14) == 0) hit_req = ~hit_req;
      if ($urandom_range(0, 1499) == 0) game_over = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        game_over = 1'b0;
      end else begin
        rst = 1'b1;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
